// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment patterns and scan FSM states
package seg_pkg;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  typedef enum logic {GUARD_S, ON_S} state_t;
endpackage

// File: rtl/seg_decode.sv
// seg_decode: 4-bit digit value to active-high {g,f,e,d,c,b,a} pattern
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] pattern
);
  // values above 9 fall through to the dash
  always_comb begin
    case (value)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with frame snapshot, zero blanking, guard gaps and PWM dimming
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLOCKSPEED     = 12000000,
  parameter int NUMCELLS       = 4,
  parameter int REFRESH_HZ     = 250,
  parameter int GUARD          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [4*NUMCELLS-1:0] bcd_in,
  input  logic [NUMCELLS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic [2:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUMCELLS-1:0]   an,
  output logic                  frame_start
);
  localparam int DWELL = CLOCKSPEED / (REFRESH_HZ * NUMCELLS);
  localparam int CW = $clog2(DWELL);
  localparam int IW = NUMCELLS > 1 ? $clog2(NUMCELLS) : 1;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [NUMCELLS-1:0] AN_OFF = {NUMCELLS{AN_ACTIVE_LOW}};

  if (DWELL < GUARD + 8 || GUARD < 1) begin : g_timing_check
    $error("seg_scan_driver: DWELL=%0d cycles is too short for GUARD=%0d", DWELL, GUARD);
  end

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            pwm_q, pwm_d;
  logic [4*NUMCELLS-1:0] snap_bcd_q, snap_bcd_d;
  logic [NUMCELLS-1:0]   snap_dp_q, snap_dp_d;
  logic                  snap_lz_q, snap_lz_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUMCELLS-1:0]   an_q, an_d;
  logic                  fs_q, fs_d;
  logic                  guard_end, on_end, slot_end, entry;
  logic                  lit, show, run;
  logic [NUMCELLS-1:0]   blank;
  logic [3:0]            digit;
  logic [6:0]            pattern;

  assign digit = snap_bcd_q[4*idx_q +: 4];

  seg_decode u_decode (
    .value  (digit),
    .pattern(pattern)
  );

  // slot sequencing: guard gap, lit dwell, next digit; snapshot taken on the first guard cycle of digit 0
  always_comb begin
    guard_end  = cnt_q == CW'(GUARD - 1);
    on_end     = cnt_q == CW'(DWELL - GUARD - 1);
    slot_end   = state_q == GUARD_S ? guard_end : on_end;
    entry      = state_q == GUARD_S && idx_q == '0 && cnt_q == '0;
    state_d    = state_q == GUARD_S ? (guard_end ? ON_S : GUARD_S) : (on_end ? GUARD_S : ON_S);
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = state_q == ON_S && on_end ? (idx_q == IW'(NUMCELLS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    pwm_d      = state_q == ON_S ? pwm_q + 1'b1 : '0;
    snap_bcd_d = entry ? bcd_in : snap_bcd_q;
    snap_dp_d  = entry ? dp_in : snap_dp_q;
    snap_lz_d  = entry ? blank_lz : snap_lz_q;
    fs_d       = entry;
  end

  // output drive: a digit is blanked when it and every more-significant digit is a bare zero
  always_comb begin
    blank = '0;
    run   = snap_lz_q;
    for (int i = NUMCELLS - 1; i >= 1; i--) begin
      run      = run && snap_bcd_q[4*i +: 4] == 4'd0 && !snap_dp_q[i];
      blank[i] = run;
    end
    lit  = state_q == ON_S && pwm_q <= bright;
    show = lit && !blank[idx_q];
    seg_d = show ? pattern ^ SEG_OFF : SEG_OFF;
    dp_d  = (show && snap_dp_q[idx_q]) ^ DP_OFF;
    an_d  = lit ? (NUMCELLS'(1) << idx_q) ^ AN_OFF : AN_OFF;
  end

  // state and registered outputs; reset aborts the current slot immediately
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q    <= GUARD_S;
      idx_q      <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table vectors, corner sequences and random stimulus against a frame-timing reference model
module tb_seg_scan_driver;
  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  int errors = 0;
  int checks = 0;
  int k = -1;
  logic [15:0] s_bcd = '0;
  logic [3:0]  s_dp = '0;
  logic        s_lz = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fs;
  logic [6:0]  pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpi;
    logic        lz;
    logic [2:0]  br;
    int          at;
    logic [12:0] exp;
  } vec_t;
  vec_t vt[$];

  seg_scan_driver #(
    .CLOCKSPEED(16000),
    .NUMCELLS  (4),
    .REFRESH_HZ(100),
    .GUARD     (2)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // k counts output cycles since reset release: 160-cycle frames of four 40-cycle slots, 2 dark then 38 lit
  task automatic model_step();
    int p, s, q;
    logic lit, blk;
    if (!rst) begin
      k = -1;
      s_bcd = '0; s_dp = '0; s_lz = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
    end else begin
      k++;
      p = k % 160; s = p / 40; q = p % 40;
      if (p == 0) begin s_bcd = bcd_in; s_dp = dp_in; s_lz = blank_lz; end
      blk = 1'b0;
      if (s_lz && s >= 1) begin
        blk = 1'b1;
        for (int j = s; j < 4; j++) if (s_bcd[4*j +: 4] != 4'd0 || s_dp[j]) blk = 1'b0;
      end
      lit = q >= 2 && (q - 2) % 8 <= int'(bright);
      e_seg = (lit && !blk) ? ~pats[s_bcd[4*s +: 4]] : 7'h7F;
      e_dp = !(lit && !blk && s_dp[s]);
      e_an = lit ? ~(4'b0001 << s) : 4'hF;
      e_fs = p == 0;
    end
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    check("model", {seg, dp, an, frame_start}, {e_seg, e_dp, e_an, e_fs});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 400 && k != target; n++) tick();
    check("reach", 13'(k), 13'(target));
  endtask

  task automatic set_in(input logic [15:0] b, input logic [3:0] d, input logic l, input logic [2:0] br);
    bcd_in = b; dp_in = d; blank_lz = l; bright = br;
  endtask

  initial begin
    int gap;
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 0,   {7'h7F, 1'b1, 4'hF, 1'b1}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 1,   {7'h7F, 1'b1, 4'hF, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 2,   {7'h19, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 42,  {7'h30, 1'b1, 4'hD, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 82,  {7'h24, 1'b1, 4'hB, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 122, {7'h79, 1'b1, 4'h7, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd7, 160, {7'h7F, 1'b1, 4'hF, 1'b1}});
    vt.push_back('{16'h0007, 4'h4, 1'b1, 3'd7, 122, {7'h7F, 1'b1, 4'h7, 1'b0}});
    vt.push_back('{16'h0007, 4'h4, 1'b1, 3'd7, 82,  {7'h40, 1'b0, 4'hB, 1'b0}});
    vt.push_back('{16'h0007, 4'h4, 1'b1, 3'd7, 42,  {7'h40, 1'b1, 4'hD, 1'b0}});
    vt.push_back('{16'h0007, 4'h4, 1'b1, 3'd7, 2,   {7'h78, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h000A, 4'h0, 1'b0, 3'd7, 2,   {7'h3F, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h0000, 4'h0, 1'b1, 3'd7, 2,   {7'h40, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h0000, 4'h0, 1'b1, 3'd7, 42,  {7'h7F, 1'b1, 4'hD, 1'b0}});
    vt.push_back('{16'h0100, 4'h0, 1'b1, 3'd7, 122, {7'h7F, 1'b1, 4'h7, 1'b0}});
    vt.push_back('{16'h0100, 4'h0, 1'b0, 3'd7, 122, {7'h40, 1'b1, 4'h7, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd1, 3,   {7'h19, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd1, 4,   {7'h7F, 1'b1, 4'hF, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd1, 10,  {7'h19, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd3, 37,  {7'h19, 1'b1, 4'hE, 1'b0}});
    vt.push_back('{16'h1234, 4'h0, 1'b0, 3'd3, 39,  {7'h7F, 1'b1, 4'hF, 1'b0}});
    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].bcd, vt[i].dpi, vt[i].lz, vt[i].br);
      do_reset();
      check("reset", {seg, dp, an, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b0});
      run_to(vt[i].at);
      check("vector", {seg, dp, an, frame_start}, vt[i].exp);
    end
    set_in(16'h0000, 4'h0, 1'b0, 3'd7);
    do_reset();
    run_to(1);
    bcd_in = 16'h0009;
    run_to(2);
    check("no_tear_early", {seg, dp, an, frame_start}, {7'h40, 1'b1, 4'hE, 1'b0});
    set_in(16'h0000, 4'h0, 1'b0, 3'd7);
    do_reset();
    run_to(85);
    bcd_in = 16'h0009;
    run_to(122);
    check("no_tear_d3", {seg, dp, an, frame_start}, {7'h40, 1'b1, 4'h7, 1'b0});
    run_to(160);
    check("next_frame", {seg, dp, an, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b1});
    run_to(162);
    check("new_digit", {seg, dp, an, frame_start}, {7'h10, 1'b1, 4'hE, 1'b0});
    set_in(16'h1234, 4'h0, 1'b0, 3'd7);
    do_reset();
    run_to(90);
    check("pre_abort", {seg, dp, an, frame_start}, {7'h24, 1'b1, 4'hB, 1'b0});
    rst = 1'b0;
    tick();
    check("abort", {seg, dp, an, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b0});
    rst = 1'b1;
    tick();
    check("restart", {seg, dp, an, frame_start}, {7'h7F, 1'b1, 4'hF, 1'b1});
    run_to(2);
    check("restart_d0", {seg, dp, an, frame_start}, {7'h19, 1'b1, 4'hE, 1'b0});
    gap = 0;
    for (int n = 0; n < 400 && !frame_start; n++) tick();
    tick();
    gap = 1;
    for (int n = 0; n < 400 && !frame_start; n++) begin tick(); gap++; end
    check("period", 13'(gap), 13'd160);
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int d = 0; d < 4; d++) bcd_in[4*d +: 4] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd0;
        dp_in = $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : 4'h0;
        blank_lz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) == 0) bright = 3'($urandom_range(0, 7));
      rst = $urandom_range(0, 1999) != 0;
      tick();
      rst = 1'b1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
